proc_param: RTL and testbench



---
 rtl/proc_pkg.sv | 44 ++++
 rtl/proc_alu.sv | 36 +++
 rtl/proc_param.sv | 175 +++++++++++++++++
 tb/tb_proc_param.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcode, step and field-width definitions for proc_param
//
// Purpose: constants and helpers shared by the processor top and its ALU.
//   opcode_t      : 3-bit instruction opcodes (mv, mvi, add, sub, mvnz, and, or, xor)
//   tstep_t       : 2-bit control step T0..T3
//   ir_field_bits : number of IR bits carrying opcode + X + Y
//   ir_spare_bits : low instruction bits left over (negative means illegal sizing)
//   is_alu_op     : opcode runs the 4-step A/G datapath sequence
package proc_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MVNZ = 3'b100,
    OP_AND  = 3'b101,
    OP_OR   = 3'b110,
    OP_XOR  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

  function automatic int ir_field_bits(input int reg_aw);
    return OPCODE_W + 2 * reg_aw;
  endfunction

  function automatic int ir_spare_bits(input int data_w, input int reg_aw);
    return data_w - ir_field_bits(reg_aw);
  endfunction

  function automatic logic is_alu_op(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/proc_alu.sv
// rtl/proc_alu.sv - combinational ALU for proc_param
//
// Purpose: computes a op b for the ALU opcodes and flags a zero result.
// Ports:
//   a      in  DATA_W  first operand (register A)
//   b      in  DATA_W  second operand (current bus value)
//   op     in  3       opcode from IR
//   result out DATA_W  a op b, modulo 2**DATA_W for add/sub
//   zero   out 1       result == 0
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = b;
    case (opcode_t'(op))
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/proc_param.sv
// rtl/proc_param.sv - parametrised multicycle single-bus processor
//
// Purpose: fetches an instruction from DIN in T0 and executes it over one
// shared bus in T1..T3. Holds IR, A, G, the zero flag, the register file,
// the bus multiplexer and the control FSM.
// Ports:
//   Clock    in  1       rising-edge clock
//   Resetn   in  1       asynchronous active-low reset
//   DIN      in  DATA_W  instruction word in T0, immediate in T1 of mvi
//   Run      in  1       start request, only looked at in T0
//   Done     out 1       high in the final step of each instruction
//   BusWires out DATA_W  shared bus value
//   Busy     out 1       high whenever the step is not T0
module proc_param
  import proc_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int REG_AW = 3
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [DATA_W-1:0] DIN,
  input  logic              Run,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires,
  output logic              Busy
);

  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int IR_W     = ir_field_bits(REG_AW);

  if (ir_spare_bits(DATA_W, REG_AW) < 0) begin : g_bad_params
    $fatal(1, "proc_param: DATA_W must be at least 3 + 2*REG_AW");
  end

  // IR keeps only opcode, X and Y; the spare low instruction bits carry no meaning.
  logic [IR_W-1:0]   ir;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] g_reg;
  logic              z_flag;
  logic [DATA_W-1:0] regs [NUM_REGS];

  tstep_t tstep;
  tstep_t tstep_next;

  opcode_t           opcode;
  logic [REG_AW-1:0] rx;
  logic [REG_AW-1:0] ry;

  // Bus drivers (one-hot per step) and register load enables.
  logic                din_out;
  logic                g_out;
  logic [NUM_REGS-1:0] r_out;
  logic                ir_in;
  logic                a_in;
  logic                g_in;
  logic [NUM_REGS-1:0] r_in;

  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  assign opcode = opcode_t'(ir[IR_W-1 -: OPCODE_W]);
  assign rx     = ir[IR_W-OPCODE_W-1 -: REG_AW];
  assign ry     = ir[REG_AW-1:0];

  proc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (a_reg),
    .b      (BusWires),
    .op     (opcode),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Control: next step, bus driver selection and load enables.
  always_comb begin
    tstep_next = tstep;
    Done       = 1'b0;
    din_out    = 1'b0;
    g_out      = 1'b0;
    r_out      = '0;
    ir_in      = 1'b0;
    a_in       = 1'b0;
    g_in       = 1'b0;
    r_in       = '0;

    case (tstep)
      T0: begin
        if (Run) begin
          ir_in      = 1'b1;
          tstep_next = T1;
        end
      end

      T1: begin
        if (is_alu_op(opcode)) begin
          r_out[rx]  = 1'b1;
          a_in       = 1'b1;
          tstep_next = T2;
        end else begin
          case (opcode)
            OP_MVI: begin
              din_out   = 1'b1;
              r_in[rx]  = 1'b1;
            end
            OP_MVNZ: begin
              r_out[ry] = 1'b1;
              r_in[rx]  = ~z_flag;
            end
            default: begin
              r_out[ry] = 1'b1;
              r_in[rx]  = 1'b1;
            end
          endcase
          Done       = 1'b1;
          tstep_next = T0;
        end
      end

      // Only ALU opcodes ever reach T2/T3.
      T2: begin
        r_out[ry]  = 1'b1;
        g_in       = 1'b1;
        tstep_next = T3;
      end

      T3: begin
        g_out      = 1'b1;
        r_in[rx]   = 1'b1;
        Done       = 1'b1;
        tstep_next = T0;
      end

      default: tstep_next = T0;
    endcase
  end

  // Drivers are one-hot, so OR-ing the gated sources is the bus; zero when idle.
  always_comb begin
    BusWires = '0;
    if (din_out) BusWires = BusWires | DIN;
    if (g_out)   BusWires = BusWires | g_reg;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (r_out[k]) BusWires = BusWires | regs[k];
    end
  end

  assign Busy = (tstep != T0);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tstep  <= T0;
      ir     <= '0;
      a_reg  <= '0;
      g_reg  <= '0;
      z_flag <= 1'b1;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
    end else begin
      tstep <= tstep_next;
      if (ir_in) ir    <= DIN[DATA_W-1 -: IR_W];
      if (a_in)  a_reg <= BusWires;
      if (g_in) begin
        g_reg  <= alu_result;
        z_flag <= alu_zero;
      end
      for (int k = 0; k < NUM_REGS; k++) begin
        if (r_in[k]) regs[k] <= BusWires;
      end
    end
  end

endmodule

// File: tb/tb_proc_param.sv
// tb/tb_proc_param.sv - self-checking bench for proc_param (9/3 and 16/4 instances)
module tb_proc_param;

  localparam logic [2:0] MV = 3'd0, MVI = 3'd1, ADD = 3'd2, SUB = 3'd3;
  localparam logic [2:0] MVNZ = 3'd4, OP_AND = 3'd5, OP_OR = 3'd6, OP_XOR = 3'd7;

  logic        Clock;
  logic        Resetn;
  logic [8:0]  din9;
  logic        run9;
  logic        done9;
  logic        busy9;
  logic [8:0]  bus9;
  logic [15:0] din16;
  logic        run16;
  logic        done16;
  logic        busy16;
  logic [15:0] bus16;

  proc_param #(.DATA_W(9), .REG_AW(3)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .DIN      (din9),
    .Run      (run9),
    .Done     (done9),
    .BusWires (bus9),
    .Busy     (busy9)
  );

  proc_param #(.DATA_W(16), .REG_AW(4)) dut16 (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .DIN      (din16),
    .Run      (run16),
    .Done     (done16),
    .BusWires (bus16),
    .Busy     (busy16)
  );

  always #5 Clock = ~Clock;

  int compared   = 0;
  int mismatched = 0;

  // Architectural reference state: register values and zero flag.
  logic [15:0] m_r [16];
  logic        m_z;
  int          w;
  int          aw;
  bit          wide;
  bit          run_hold;
  logic [31:0] last_bus1;
  logic [31:0] last_busf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_bus();
    return wide ? {16'h0, bus16} : {23'h0, bus9};
  endfunction

  function automatic logic [31:0] obs_done();
    return {31'h0, wide ? done16 : done9};
  endfunction

  function automatic logic [31:0] obs_busy();
    return {31'h0, wide ? busy16 : busy9};
  endfunction

  task automatic drive(input logic run, input logic [31:0] din);
    if (wide) begin
      run16 = run;
      din16 = din[15:0];
    end else begin
      run9 = run;
      din9 = din[8:0];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 16'h0;
    m_z = 1'b1;
  endtask

  function automatic logic [31:0] mk_instr(input logic [2:0] op, input int x, input int y);
    int spare;
    logic [31:0] junk;
    spare = w - 3 - 2 * aw;
    junk  = $urandom & ((32'd1 << spare) - 32'd1);
    return ({29'h0, op} << (w - 3)) | (32'(x) << (w - 3 - aw)) | (32'(y) << spare) | junk;
  endfunction

  task automatic exec(input logic [2:0] op, input int x, input int y,
                      input logic [31:0] imm, input string tag);
    logic [31:0] mask, a, b, res, instr;
    logic [31:0] exp_bus [4];
    logic        rn;
    int          n;
    mask  = (32'd1 << w) - 32'd1;
    instr = mk_instr(op, x, y);
    a = {16'h0, m_r[x]};
    b = {16'h0, m_r[y]};
    exp_bus[0] = 32'h0;
    exp_bus[1] = 32'h0;
    exp_bus[2] = 32'h0;
    exp_bus[3] = 32'h0;
    n = 2;
    case (op)
      MV: begin
        exp_bus[1] = b;
        m_r[x] = b[15:0];
      end
      MVI: begin
        exp_bus[1] = imm & mask;
        m_r[x] = exp_bus[1][15:0];
      end
      MVNZ: begin
        exp_bus[1] = b;
        if (!m_z) m_r[x] = b[15:0];
      end
      default: begin
        n = 4;
        case (op)
          ADD:     res = (a + b) & mask;
          SUB:     res = (a - b) & mask;
          OP_AND:  res = a & b;
          OP_OR:   res = a | b;
          default: res = a ^ b;
        endcase
        exp_bus[1] = a;
        exp_bus[2] = b;
        exp_bus[3] = res;
        m_r[x] = res[15:0];
        m_z = (res == 32'h0);
      end
    endcase
    for (int s = 0; s < n; s++) begin
      @(negedge Clock);
      rn = run_hold ? 1'b1 : 1'($urandom_range(0, 1));
      if (s == 0)                  drive(1'b1, instr);
      else if (s == 1 && op == MVI) drive(rn, imm);
      else                         drive(rn, $urandom);
      #1;
      chk($sformatf("%s.s%0d.bus", tag, s), obs_bus(), exp_bus[s]);
      chk($sformatf("%s.s%0d.done", tag, s), obs_done(), {31'h0, s == n - 1});
      chk($sformatf("%s.s%0d.busy", tag, s), obs_busy(), {31'h0, s != 0});
      if (s == 1)     last_bus1 = obs_bus();
      if (s == n - 1) last_busf = obs_bus();
    end
  endtask

  task automatic idle(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clock);
      drive(1'b0, $urandom);
      #1;
      chk({tag, ".bus"}, obs_bus(), 32'h0);
      chk({tag, ".done"}, obs_done(), 32'h0);
      chk({tag, ".busy"}, obs_busy(), 32'h0);
    end
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge Clock);
    Resetn = 1'b0;
    #1;
    chk({tag, ".bus"}, obs_bus(), 32'h0);
    chk({tag, ".done"}, obs_done(), 32'h0);
    chk({tag, ".busy"}, obs_busy(), 32'h0);
    @(negedge Clock);
    Resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] instr;
    Clock = 1'b0;
    Resetn = 1'b0;
    din9 = '0;  run9 = 1'b0;
    din16 = '0; run16 = 1'b0;
    wide = 1'b0; w = 9; aw = 3; run_hold = 1'b0;
    model_reset();

    #1;
    chk("rst.bus9", {23'h0, bus9}, 32'h0);
    chk("rst.done9", {31'h0, done9}, 32'h0);
    chk("rst.busy9", {31'h0, busy9}, 32'h0);
    chk("rst.bus16", {16'h0, bus16}, 32'h0);
    chk("rst.busy16", {31'h0, busy16}, 32'h0);
    @(negedge Clock);
    Resetn = 1'b1;
    idle(2, "idle0");

    // Directed sequence.
    exec(MVI, 0, 0, 32'd5, "mvi_r0_5");      chk("mvi_r0_5.val", last_bus1, 32'd5);
    exec(MV, 7, 0, 32'd0, "mv_r7_r0");       chk("mv_r7_r0.val", last_bus1, 32'd5);
    exec(MVI, 1, 0, 32'd3, "mvi_r1_3");
    exec(ADD, 0, 1, 32'd0, "add_r0_r1");     chk("add_r0_r1.val", last_busf, 32'd8);
    exec(MV, 2, 0, 32'd0, "mv_r2_r0");       chk("mv_r2_r0.val", last_bus1, 32'd8);
    exec(SUB, 1, 0, 32'd0, "sub_r1_r0");     chk("sub_r1_r0.val", last_busf, 32'h1FB);
    exec(OP_XOR, 3, 3, 32'd0, "xor_r3_r3");  chk("xor_r3_r3.val", last_busf, 32'h0);
    exec(MVNZ, 4, 0, 32'd0, "mvnz_z1");
    exec(MV, 4, 4, 32'd0, "peek_r4_a");      chk("mvnz_z1.r4", last_bus1, 32'h0);
    exec(SUB, 1, 0, 32'd0, "sub_again");     chk("sub_again.val", last_busf, 32'h1F3);
    exec(MVNZ, 4, 0, 32'd0, "mvnz_z0");
    exec(MV, 4, 4, 32'd0, "peek_r4_b");      chk("mvnz_z0.r4", last_bus1, 32'd8);

    // Run held high: back-to-back instructions with a single T0 each.
    run_hold = 1'b1;
    exec(MVI, 5, 0, 32'h1AA, "hold_mvi");
    exec(OP_AND, 5, 2, 32'd0, "hold_and");   chk("hold_and.val", last_busf, 32'h008);
    exec(OP_OR, 5, 7, 32'd0, "hold_or");     chk("hold_or.val", last_busf, 32'h00D);
    exec(MV, 6, 5, 32'd0, "hold_mv");        chk("hold_mv.val", last_bus1, 32'h00D);
    run_hold = 1'b0;
    idle(1, "idle1");

    // Random instruction stream against the reference model.
    for (int i = 0; i < 150; i++) begin
      exec(3'($urandom_range(0, 7)), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 2), "rnd_idle");
    end

    // Asynchronous reset in the middle of T2 of an add.
    @(negedge Clock);
    instr = mk_instr(ADD, 0, 1);
    drive(1'b1, instr);
    @(negedge Clock);
    drive(1'b0, $urandom);
    @(negedge Clock);
    drive(1'b0, $urandom);
    #1;
    chk("arst.t2.bus", obs_bus(), {16'h0, m_r[1]});
    chk("arst.t2.busy", obs_busy(), 32'h1);
    #2;
    Resetn = 1'b0;
    #1;
    chk("arst.done", obs_done(), 32'h0);
    chk("arst.busy", obs_busy(), 32'h0);
    chk("arst.bus", obs_bus(), 32'h0);
    @(negedge Clock);
    Resetn = 1'b1;
    model_reset();
    exec(MV, 2, 0, 32'd0, "post_rst_mv");    chk("post_rst_mv.val", last_bus1, 32'h0);
    exec(MV, 0, 0, 32'd0, "post_rst_r0");    chk("post_rst_r0.val", last_bus1, 32'h0);
    exec(MVNZ, 3, 0, 32'd0, "post_rst_z");

    // 16-bit / 16-register instance.
    wide = 1'b1; w = 16; aw = 4;
    pulse_reset("rst16");
    exec(MVI, 15, 0, 32'hFFFF, "w_mvi");     chk("w_mvi.val", last_bus1, 32'hFFFF);
    exec(ADD, 15, 15, 32'd0, "w_add");       chk("w_add.val", last_busf, 32'hFFFE);
    exec(MVNZ, 0, 15, 32'd0, "w_mvnz");
    exec(MV, 0, 0, 32'd0, "w_peek");         chk("w_mvnz.r0", last_bus1, 32'hFFFE);
    for (int i = 0; i < 40; i++) begin
      exec(3'($urandom_range(0, 7)), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom, $sformatf("wrnd%0d", i));
    end
    idle(1, "idle16");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
